fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 60 ++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Turns a 1-cycle-latency FIFO read port (rd_en -> buf_out) into a valid/ready
// stream through a 2-entry skid buffer, with a running transfer counter.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buf_empty,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] buf_out,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  logic                  inflight;
  logic [DATA_WIDTH-1:0] entry1;
  logic                  xfer;
  logic [2:0]            committed;
  logic [1:0]            occ_after_xfer;
  logic [1:0]            occ_next;

  assign xfer = m_valid && m_ready;

  // Words already owned (buffered or in flight) once this cycle's transfer leaves.
  // Issuing a read only while this is below 2 is what keeps the buffer from overflowing.
  assign committed = {1'b0, occupancy} + {2'b0, inflight} - {2'b0, xfer};
  assign rd_en     = !rst && !buf_empty && (committed < 3'd2);

  assign occ_after_xfer = occupancy - {1'b0, xfer};
  assign occ_next       = occ_after_xfer + {1'b0, inflight};

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight  <= 1'b0;
      occupancy <= 2'd0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      entry1    <= '0;
      pop_count <= '0;
    end else begin
      inflight  <= rd_en;
      occupancy <= occ_next;
      m_valid   <= (occ_next != 2'd0);
      if (xfer) begin
        m_data    <= entry1;
        pop_count <= pop_count + CNT_WIDTH'(1);
      end
      // Captured word lands at the tail after any same-cycle transfer has shifted.
      if (inflight) begin
        if (occ_after_xfer == 2'd0) m_data <= buf_out;
        else                        entry1 <= buf_out;
      end
    end
  end

endmodule
